// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the 4-way round-robin request arbiter.
package arb_pkg;

  localparam int NUM_REQ          = 4;
  localparam int IDX_W            = 2;
  localparam int MAX_HOLD_DEFAULT = 8;
  localparam int HOLD_W           = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/encoder_4x2.sv
// One-hot to binary encoder; an all-zero input encodes to index 0.
module encoder_4x2
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] contrib [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_contrib
    assign contrib[gi] = onehot[gi] ? IDX_W'(gi) : '0;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = idx | contrib[i];
    end
  end

endmodule

// File: rtl/req_arbiter_4.sv
// Four-requester round-robin arbiter with bounded hold time and one idle
// cycle between consecutive grants.
module req_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  state_t             state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [IDX_W-1:0]   gnt_idx_reg;
  logic               gnt_valid_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic [IDX_W-1:0]   last_reg;

  logic [IDX_W-1:0]   base;
  logic [NUM_REQ-1:0] rot_req;
  logic [NUM_REQ-1:0] rot_win;
  logic [IDX_W-1:0]   win_off;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               release_now;

  // Rotate so the requester just after the last winner sits at bit 0.
  assign base = last_reg + IDX_W'(1);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    localparam logic [IDX_W-1:0] OFF = IDX_W'(gi);
    assign rot_req[gi] = req[base + OFF];
  end

  assign rot_win = rot_req & (~rot_req + NUM_REQ'(1));

  encoder_4x2 u_enc (
    .onehot (rot_win),
    .idx    (win_off)
  );

  assign win_idx    = base + win_off;
  assign win_onehot = NUM_REQ'(1) << win_idx;

  assign release_now = done || !req[gnt_idx_reg] || (hold_cnt_reg == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      hold_cnt_reg  <= '0;
      last_reg      <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            state_reg     <= GRANT;
            gnt_reg       <= win_onehot;
            gnt_idx_reg   <= win_idx;
            gnt_valid_reg <= 1'b1;
            hold_cnt_reg  <= '0;
            last_reg      <= win_idx;
          end else begin
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
          end else if (hold_cnt_reg != '1) begin
            hold_cnt_reg  <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        default: begin
          state_reg     <= IDLE;
          gnt_reg       <= '0;
          gnt_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = gnt_idx_reg;
  assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed bench for req_arbiter_4: expected outputs queued per step, checked one edge later.
module tb_req_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  req_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Structural invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    assert ($onehot0(gnt)) else begin
      miscompares++;
      $error("FAIL onehot gnt observed %b required one-hot or zero", gnt);
    end
    assert (gnt_valid === (|gnt)) else begin
      miscompares++;
      $error("FAIL valid_eq observed gnt_valid %b required %b", gnt_valid, |gnt);
    end
  end

  task automatic step(input logic r, input logic [3:0] rq, input logic d,
                      input logic [3:0] eg, input logic [1:0] ei, input logic ev,
                      input string tag);
    exp_t e;
    rst  = r;
    req  = rq;
    done = d;
    sb_q.push_back('{g: eg, i: ei, v: ev});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    vectors++;
    assert (gnt === e.g) else begin
      miscompares++;
      $error("FAIL %s gnt observed %b expected %b", tag, gnt, e.g);
    end
    assert (gnt_idx === e.i) else begin
      miscompares++;
      $error("FAIL %s gnt_idx observed %0d expected %0d", tag, gnt_idx, e.i);
    end
    assert (gnt_valid === e.v) else begin
      miscompares++;
      $error("FAIL %s gnt_valid observed %b expected %b", tag, gnt_valid, e.v);
    end
    $display("step %-10s rst=%b req=%b done=%b -> gnt=%b idx=%0d valid=%b",
             tag, r, rq, d, gnt, gnt_idx, gnt_valid);
  endtask

  initial begin
    // Basic grant and done release
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "reset");
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "reset2");
    step(0, 4'b0001, 0, 4'b0001, 2'd0, 1, "basic_gnt");
    step(0, 4'b0001, 1, 4'b0000, 2'd0, 0, "basic_rel");
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "idle");

    // Round-robin order with all requesting; done while idle is ignored
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "rr_reset");
    step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, "rr_g0");
    step(0, 4'b1111, 1, 4'b0000, 2'd0, 0, "rr_r0");
    step(0, 4'b1111, 1, 4'b0010, 2'd1, 1, "rr_g1");
    step(0, 4'b1111, 1, 4'b0000, 2'd1, 0, "rr_r1");
    step(0, 4'b1111, 0, 4'b0100, 2'd2, 1, "rr_g2");
    step(0, 4'b1111, 1, 4'b0000, 2'd2, 0, "rr_r2");
    step(0, 4'b1111, 0, 4'b1000, 2'd3, 1, "rr_g3");
    step(0, 4'b1111, 1, 4'b0000, 2'd3, 0, "rr_r3");
    step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, "rr_g0b");
    step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, "rr_r0b");
    step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, "idle_done");

    // Hold limit: exactly 8 grant cycles, one idle, then regrant
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "hold_reset");
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, "hold_g");
    for (int k = 1; k < 8; k++)
      step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, "hold_keep");
    step(0, 4'b0100, 0, 4'b0000, 2'd2, 0, "hold_rel");
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, "hold_regnt");
    // Done coinciding with hold limit: single release, pointer stays at 2
    for (int k = 1; k < 8; k++)
      step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, "hold2_keep");
    step(0, 4'b0100, 1, 4'b0000, 2'd2, 0, "hold2_rel");
    step(0, 4'b0101, 0, 4'b0001, 2'd0, 1, "after_both");
    step(0, 4'b0101, 1, 4'b0000, 2'd0, 0, "after_rel");

    // Holder deasserts its request
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "drop_reset");
    step(0, 4'b0010, 0, 4'b0010, 2'd1, 1, "drop_g1");
    step(0, 4'b1000, 0, 4'b0000, 2'd1, 0, "drop_rel");
    step(0, 4'b1000, 0, 4'b1000, 2'd3, 1, "drop_g3");
    step(0, 4'b0000, 0, 4'b0000, 2'd3, 0, "drop_rel3");

    // No preemption by other requesters
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "np_reset");
    step(0, 4'b0001, 0, 4'b0001, 2'd0, 1, "np_g0");
    step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, "np_hold");
    step(0, 4'b1110, 0, 4'b0000, 2'd0, 0, "np_rel");
    step(0, 4'b1110, 0, 4'b0010, 2'd1, 1, "np_g1");

    // Reset mid-grant drops it; rearbitration restarts from requester 0
    step(1, 4'b0011, 0, 4'b0000, 2'd0, 0, "rst_mid");
    step(0, 4'b0011, 0, 4'b0001, 2'd0, 1, "rst_regnt");
    step(0, 4'b0011, 1, 4'b0000, 2'd0, 0, "rst_rel");
    step(1, 4'b1111, 1, 4'b0000, 2'd0, 0, "rst_prec");
    step(0, 4'b1000, 0, 4'b1000, 2'd3, 1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
